// File: rtl/lc_mem_arb_pkg.sv
// Shared definitions for the layer-controller memory arbiter: FSM encoding,
// default address/data widths and the grant index width helper.
package lc_mem_arb_pkg;

  localparam int LC_MEM_ADDR_WIDTH = 32;
  localparam int LC_MEM_DATA_WIDTH = 32;
  localparam int DEF_AW = LC_MEM_ADDR_WIDTH - 2;
  localparam int DEF_DW = LC_MEM_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/lc_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after
// last_grant (wrapping), with last_grant itself considered last.
module lc_rr_pick
  import lc_mem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] winner_oh,
  output logic [IW-1:0]    winner_idx
);

  logic found_s;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found_s    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found_s && req[i] && (i == ((int'(last_grant) + k) % N_REQ))) begin
          found_s      = 1'b1;
          winner_oh[i] = 1'b1;
          winner_idx   = IW'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/lc_mem_arbiter.sv
// Round-robin arbiter sharing one 4-phase memory port among N_REQ requesters.
// Optional issue timeout with error abort is enabled by LC_MEM_ARB_TIMEOUT_EN.
module lc_mem_arbiter
  import lc_mem_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    WRITE,
  input  logic [N_REQ*AW-1:0] ADDR,
  input  logic [N_REQ*DW-1:0] WDATA,
  output logic [N_REQ-1:0]    ACK,
  output logic [N_REQ-1:0]    ERR,
  output logic [DW-1:0]       RDATA,
  output logic                MEM_REQ_OUT,
  output logic                MEM_WRITE,
  output logic [AW-1:0]       MEM_AOUT,
  output logic [DW-1:0]       MEM_DOUT,
  input  logic                MEM_ACK_IN,
  input  logic [DW-1:0]       MEM_DIN
);

  localparam int IW = idx_width(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] req_q;
  logic             mem_ack_q;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_write_q, mem_write_d;
  logic [AW-1:0]    mem_aout_q, mem_aout_d;
  logic [DW-1:0]    mem_dout_q, mem_dout_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] pick_oh_s;
  logic [IW-1:0]    pick_idx_s;
  logic [N_REQ-1:0] grant_oh_s;

`ifdef LC_MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q, err_d;
`endif

  lc_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (req_q),
    .last_grant (last_grant_q),
    .winner_oh  (pick_oh_s),
    .winner_idx (pick_idx_s)
  );

  assign grant_oh_s = N_REQ'(1'b1) << grant_q;

  // REQ and MEM_ACK_IN are registered once before the FSM looks at them
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      mem_ack_q    <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_aout_q   <= '0;
      mem_dout_q   <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
`ifdef LC_MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= REQ;
      mem_ack_q    <= MEM_ACK_IN;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_aout_q   <= mem_aout_d;
      mem_dout_q   <= mem_dout_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
`ifdef LC_MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_aout_d   = mem_aout_q;
    mem_dout_d   = mem_dout_q;
    rdata_d      = rdata_q;
    ack_d        = ack_q;
`ifdef LC_MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // a slow memory release still in progress blocks the next grant
        if ((|req_q) && !mem_ack_q) begin
          grant_d     = pick_idx_s;
          mem_aout_d  = ADDR[pick_idx_s*AW +: AW];
          mem_dout_d  = WDATA[pick_idx_s*DW +: DW];
          mem_write_d = |(WRITE & pick_oh_s);
          mem_req_d   = 1'b1;
`ifdef LC_MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack_q) begin
          mem_req_d = 1'b0;
          if (!mem_write_q) begin
            rdata_d = MEM_DIN;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_RELEASE;
        end
`ifdef LC_MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = grant_oh_s;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        else begin
          state_d = ST_ISSUE;
        end
`endif
      end
      ST_RELEASE: begin
        if (!mem_ack_q) begin
          ack_d        = grant_oh_s;
          last_grant_d = grant_q;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RESP: begin
        if (!req_q[grant_q]) begin
          ack_d   = '0;
`ifdef LC_MEM_ARB_TIMEOUT_EN
          err_d   = '0;
`endif
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ACK         = ack_q;
    RDATA       = rdata_q;
    MEM_REQ_OUT = mem_req_q;
    MEM_WRITE   = mem_write_q;
    MEM_AOUT    = mem_aout_q;
    MEM_DOUT    = mem_dout_q;
`ifdef LC_MEM_ARB_TIMEOUT_EN
    ERR         = err_q;
`else
    ERR         = '0;
`endif
  end

endmodule

// File: tb/tb_lc_mem_arbiter.sv
// Self-checking bench for lc_mem_arbiter: a responding memory model, a
// scoreboard of expected memory transactions, and per-scenario tasks.
module tb_lc_mem_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int TO    = 8;

  logic                CLK = 1'b0;
  logic                RESET;
  logic [N_REQ-1:0]    REQ, WRITE;
  logic [N_REQ*AW-1:0] ADDR;
  logic [N_REQ*DW-1:0] WDATA;
  logic [N_REQ-1:0]    ACK, ERR;
  logic [DW-1:0]       RDATA;
  logic                MEM_REQ_OUT, MEM_WRITE;
  logic [AW-1:0]       MEM_AOUT;
  logic [DW-1:0]       MEM_DOUT;
  logic                MEM_ACK_IN;
  logic [DW-1:0]       MEM_DIN;

  logic          req_v   [2];
  logic          wr_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];

  assign REQ   = {req_v[1], req_v[0]};
  assign WRITE = {wr_v[1], wr_v[0]};
  assign ADDR  = {addr_v[1], addr_v[0]};
  assign WDATA = {wdata_v[1], wdata_v[0]};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t    exp_q[$];
  int      grant_log[$];
  int      checks   = 0;
  int      failures = 0;
  bit      mem_enable = 1'b1;
  int      mem_hold   = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic    prev_mreq = 1'b0;

  lc_mem_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WRITE(WRITE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .MEM_REQ_OUT(MEM_REQ_OUT), .MEM_WRITE(MEM_WRITE),
    .MEM_AOUT(MEM_AOUT), .MEM_DOUT(MEM_DOUT), .MEM_ACK_IN(MEM_ACK_IN), .MEM_DIN(MEM_DIN)
  );

  always #5 CLK = ~CLK;

  // memory model: acks 3ns after the edge that raised MEM_REQ_OUT, releases mem_hold cycles late
  initial begin
    MEM_ACK_IN = 1'b0;
    MEM_DIN    = '0;
    forever begin
      @(posedge CLK); #3;
      if (mem_enable && MEM_REQ_OUT === 1'b1 && !MEM_ACK_IN) begin
        MEM_DIN    = mem_rdata;
        MEM_ACK_IN = 1'b1;
        for (int n = 0; n < 50 && MEM_REQ_OUT === 1'b1; n++) begin
          @(posedge CLK); #3;
        end
        for (int k = 0; k < mem_hold; k++) begin
          @(posedge CLK); #3;
        end
        MEM_ACK_IN = 1'b0;
        MEM_DIN    = '0;
      end
    end
  end

  // scoreboard on each memory issue, plus ACK/ERR one-hot check every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MEM_REQ_OUT === 1'b1 && prev_mreq === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_mem_req: got addr=%h, required no request", MEM_AOUT);
        end else begin
          e = exp_q.pop_front();
          if (MEM_AOUT !== e.addr || MEM_WRITE !== e.wr || (e.wr && MEM_DOUT !== e.wdata)) begin
            failures++;
            $display("FAIL mem_txn: got addr=%h wr=%b dout=%h, required addr=%h wr=%b dout=%h",
                     MEM_AOUT, MEM_WRITE, MEM_DOUT, e.addr, e.wr, e.wdata);
          end
        end
      end
      prev_mreq = MEM_REQ_OUT;
      checks++;
      if (!$onehot0(ACK) || !$onehot0(ERR)) begin
        failures++;
        $display("FAIL onehot: got ACK=%b ERR=%b, required at most one bit set", ACK, ERR);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a; e.wr = w; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int i, input logic level, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (ACK[i] === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_mreq(input logic level, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (MEM_REQ_OUT === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (ACK !== 2'b00 || ERR !== 2'b00 || MEM_REQ_OUT !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ACK=%b ERR=%b MREQ=%b, required 00 00 0", ACK, ERR, MEM_REQ_OUT);
    end
    checks++;
    if (RDATA !== '0 || MEM_AOUT !== '0 || MEM_WRITE !== 1'b0 || MEM_DOUT !== '0) begin
      failures++;
      $display("FAIL reset_data: got RDATA=%h AOUT=%h WR=%b DOUT=%h, required all 0",
               RDATA, MEM_AOUT, MEM_WRITE, MEM_DOUT);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single_read();
    bit ok;
    mem_rdata = 32'hDEAD_BEEF;
    addr_v[0] = 30'h10; wr_v[0] = 1'b0;
    push_exp(30'h10, 1'b0, '0);
    req_v[0] = 1'b1;
    @(negedge CLK);
    checks++;
    if (MEM_REQ_OUT !== 1'b0) begin
      failures++;
      $display("FAIL read_latency_early: got MREQ=%b, required 0", MEM_REQ_OUT);
    end
    @(negedge CLK);
    checks++;
    if (MEM_REQ_OUT !== 1'b1 || MEM_AOUT !== 30'h10 || MEM_WRITE !== 1'b0) begin
      failures++;
      $display("FAIL read_issue: got MREQ=%b AOUT=%h WR=%b, required 1 10 0", MEM_REQ_OUT, MEM_AOUT, MEM_WRITE);
    end
    wait_ack(0, 1'b1, ok);
    checks++;
    if (!ok || ACK !== 2'b01 || RDATA !== 32'hDEAD_BEEF || ERR !== 2'b00) begin
      failures++;
      $display("FAIL read_ack: got ok=%b ACK=%b RDATA=%h ERR=%b, required 1 01 deadbeef 00", ok, ACK, RDATA, ERR);
    end
    req_v[0] = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (ACK !== 2'b00) begin
      failures++;
      $display("FAIL read_ack_fall: got ACK=%b, required 00", ACK);
    end
  endtask

  task automatic test_write();
    bit ok;
    int pulses;
    logic [DW-1:0] rd_at_ack;
    mem_rdata = 32'h1234_5678;
    addr_v[1] = 30'h3; wr_v[1] = 1'b1; wdata_v[1] = 32'h55AA;
    push_exp(30'h3, 1'b1, 32'h55AA);
    req_v[1] = 1'b1;
    wait_mreq(1'b1, ok);
    checks++;
    if (!ok || MEM_WRITE !== 1'b1 || MEM_DOUT !== 32'h55AA) begin
      failures++;
      $display("FAIL write_issue: got ok=%b WR=%b DOUT=%h, required 1 1 55aa", ok, MEM_WRITE, MEM_DOUT);
    end
    req_v[1] = 1'b0;
    pulses = 0;
    rd_at_ack = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (ACK === 2'b10) begin pulses++; rd_at_ack = RDATA; end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL write_ack_pulse: got %0d cycles, required 1", pulses);
    end
    checks++;
    if (rd_at_ack !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_rdata_kept: got %h, required deadbeef", rd_at_ack);
    end
    wr_v[1] = 1'b0;
  endtask

  task automatic requester_loop(input int i, input int n_txn);
    bit ok;
    for (int t = 0; t < n_txn; t++) begin
      req_v[i] = 1'b1;
      wait_ack(i, 1'b1, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_ack_timeout: requester %0d got no ACK, required ACK", i);
      end
      grant_log.push_back(i);
      req_v[i] = 1'b0;
      wait_ack(i, 1'b0, ok);
    end
  endtask

  task automatic test_back_to_back();
    int exp_order[4] = '{0, 1, 0, 1};
    mem_rdata = 32'hA5A5_0000;
    addr_v[0] = 30'h100; addr_v[1] = 30'h200;
    grant_log.delete();
    push_exp(30'h100, 1'b0, '0); push_exp(30'h200, 1'b0, '0);
    push_exp(30'h100, 1'b0, '0); push_exp(30'h200, 1'b0, '0);
    fork
      requester_loop(0, 2);
      requester_loop(1, 2);
    join
    checks++;
    if (grant_log.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] != exp_order[k]) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %0d, required %0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_slow_memory();
    bit ok;
    mem_hold = 5;
    mem_rdata = 32'h0BAD_F00D;
    addr_v[1] = 30'h300; addr_v[0] = 30'h400;
    push_exp(30'h300, 1'b0, '0); push_exp(30'h400, 1'b0, '0);
    req_v[1] = 1'b1;
    wait_mreq(1'b1, ok);
    wait_mreq(1'b0, ok);
    req_v[0] = 1'b1;
    req_v[1] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (MEM_ACK_IN !== 1'b1) break;
      checks++;
      if (MEM_REQ_OUT !== 1'b0 || ACK !== 2'b00) begin
        failures++;
        $display("FAIL slow_hold: got MREQ=%b ACK=%b, required 0 00", MEM_REQ_OUT, ACK);
      end
      @(negedge CLK);
    end
    wait_ack(1, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL slow_ack1: got no ACK[1], required ACK[1]");
    end
    wait_ack(0, 1'b1, ok);
    checks++;
    if (!ok || RDATA !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL slow_ack0: got ok=%b RDATA=%h, required 1 0badf00d", ok, RDATA);
    end
    req_v[0] = 1'b0;
    wait_ack(0, 1'b0, ok);
    mem_hold = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem_enable = 1'b0;
    addr_v[0] = 30'h50;
    push_exp(30'h50, 1'b0, '0);
    req_v[0] = 1'b1;
    wait_mreq(1'b1, ok);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (MEM_REQ_OUT !== 1'b0 || ACK !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid: got MREQ=%b ACK=%b, required 0 00", MEM_REQ_OUT, ACK);
    end
    RESET = 1'b0;
    req_v[0] = 1'b0;
    mem_enable = 1'b1;
    mem_rdata = 32'h0000_C0DE;
    repeat (2) @(negedge CLK);
    addr_v[0] = 30'h60; addr_v[1] = 30'h70;
    push_exp(30'h60, 1'b0, '0); push_exp(30'h70, 1'b0, '0);
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (ACK !== 2'b00) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || ACK !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_grant: got ok=%b ACK=%b, required 1 01", ok, ACK);
    end
    req_v[0] = 1'b0;
    wait_ack(1, 1'b1, ok);
    req_v[1] = 1'b0;
    wait_ack(1, 1'b0, ok);
  endtask

`ifdef LC_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int hi;
    mem_enable = 1'b0;
    addr_v[0] = 30'h77;
    push_exp(30'h77, 1'b0, '0);
    req_v[0] = 1'b1;
    wait_mreq(1'b1, ok);
    hi = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (MEM_REQ_OUT !== 1'b1) break;
      hi++;
    end
    checks++;
    if (hi != TO) begin
      failures++;
      $display("FAIL timeout_len: got %0d cycles, required %0d", hi, TO);
    end
    wait_ack(0, 1'b1, ok);
    checks++;
    if (!ok || ACK !== 2'b01 || ERR !== 2'b01 || RDATA !== '0) begin
      failures++;
      $display("FAIL timeout_resp: got ok=%b ACK=%b ERR=%b RDATA=%h, required 1 01 01 0", ok, ACK, ERR, RDATA);
    end
    req_v[0] = 1'b0;
    wait_ack(0, 1'b0, ok);
    checks++;
    if (ERR !== 2'b00) begin
      failures++;
      $display("FAIL timeout_err_clear: got ERR=%b, required 00", ERR);
    end
    mem_enable = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_slow_memory();
    test_reset_mid();
`ifdef LC_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
